// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - run/opcode/memory handshake and micro-op outputs of the sequencer
interface micro_sequencer_if;
  logic        Run;
  logic [2:0]  Opcode;
  logic        MemReady;
  logic [12:0] MicroCode;
  logic        Halted;
  logic        Busy;
  logic        InstrDone;

  // Control side: drives run, opcode and memory-ready, observes the micro-op word
  modport master (
    output Run, Opcode, MemReady,
    input  MicroCode, Halted, Busy, InstrDone
  );

  // Sequencer side
  modport slave (
    input  Run, Opcode, MemReady,
    output MicroCode, Halted, Busy, InstrDone
  );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - fetch/decode/execute stepper emitting one-hot micro-op words
module micro_sequencer #(
  parameter bit START_ON_RESET = 1'b0,
  parameter bit MEM_WAIT       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  micro_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_F3   = 4'd3,
    S_DEC  = 4'd4,
    S_ER   = 4'd5,
    S_EL   = 4'd6,
    S_EA   = 4'd7,
    S_ES   = 4'd8,
    S_EW1  = 4'd9,
    S_EW2  = 4'd10,
    S_EJ   = 4'd11,
    S_EZ   = 4'd12,
    S_HALT = 4'd13
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDAC = 3'b001;
  localparam logic [2:0] OP_STAC = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_JUMP = 3'b101;
  localparam logic [2:0] OP_JMPZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // One-hot micro-op bits
  localparam logic [12:0] UC_AR_DR_PCINC = 13'h1000;
  localparam logic [12:0] UC_IR_DR       = 13'h0800;
  localparam logic [12:0] UC_AC_DR       = 13'h0400;
  localparam logic [12:0] UC_MEM_WR      = 13'h0200;
  localparam logic [12:0] UC_PC_DR       = 13'h0100;
  localparam logic [12:0] UC_PC_DR_Z     = 13'h0080;
  localparam logic [12:0] UC_MEM_RD      = 13'h0040;
  localparam logic [12:0] UC_AR_PC       = 13'h0020;
  localparam logic [12:0] UC_DR_AC       = 13'h0008;
  localparam logic [12:0] UC_ADD         = 13'h0004;
  localparam logic [12:0] UC_SUB         = 13'h0002;

  state_t      state;
  state_t      nxt;
  logic [2:0]  op_q;
  logic        run_armed;
  logic        mem_done;
  logic [12:0] micro_q;
  logic        halted_q;
  logic        busy_q;

  // With waiting disabled every memory micro-op completes in its first cycle
  assign mem_done = (MEM_WAIT == 1'b0) || bus.MemReady;

  // Micro-op word for each state; idle, halt and any stray encoding emit nothing
  function automatic logic [12:0] uc_of(input state_t s);
    case (s)
      S_F1:    uc_of = UC_AR_PC;
      S_F2:    uc_of = UC_MEM_RD;
      S_F3:    uc_of = UC_IR_DR;
      S_DEC:   uc_of = UC_AR_DR_PCINC;
      S_ER:    uc_of = UC_MEM_RD;
      S_EL:    uc_of = UC_AC_DR;
      S_EA:    uc_of = UC_ADD;
      S_ES:    uc_of = UC_SUB;
      S_EW1:   uc_of = UC_DR_AC;
      S_EW2:   uc_of = UC_MEM_WR;
      S_EJ:    uc_of = UC_PC_DR;
      S_EZ:    uc_of = UC_PC_DR_Z;
      default: uc_of = 13'h0000;
    endcase
  endfunction

  // Next-state selection; DEC looks at the live opcode, ER at the latched copy
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = (START_ON_RESET || bus.Run) ? S_F1 : S_IDLE;
      S_F1:   nxt = S_F2;
      S_F2:   nxt = mem_done ? S_F3 : S_F2;
      S_F3:   nxt = S_DEC;
      S_DEC: begin
        case (bus.Opcode)
          OP_NOP:  nxt = S_F1;
          OP_LDAC: nxt = S_ER;
          OP_ADD:  nxt = S_ER;
          OP_SUB:  nxt = S_ER;
          OP_STAC: nxt = S_EW1;
          OP_JUMP: nxt = S_EJ;
          OP_JMPZ: nxt = S_EZ;
          OP_HALT: nxt = S_HALT;
          default: nxt = S_IDLE;
        endcase
      end
      S_ER: begin
        if (!mem_done) begin
          nxt = S_ER;
        end else begin
          case (op_q)
            OP_ADD:  nxt = S_EA;
            OP_SUB:  nxt = S_ES;
            default: nxt = S_EL;
          endcase
        end
      end
      S_EL:   nxt = S_F1;
      S_EA:   nxt = S_F1;
      S_ES:   nxt = S_F1;
      S_EW1:  nxt = S_EW2;
      S_EW2:  nxt = mem_done ? S_F1 : S_EW2;
      S_EJ:   nxt = S_F1;
      S_EZ:   nxt = S_F1;
      S_HALT: nxt = (run_armed && bus.Run) ? S_F1 : S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  // State register with registered Moore outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      run_armed <= 1'b0;
      micro_q   <= 13'h0000;
      halted_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state    <= nxt;
      micro_q  <= uc_of(nxt);
      halted_q <= (nxt == S_HALT);
      busy_q   <= (nxt != S_IDLE) && (nxt != S_HALT);
      if (state == S_DEC) begin
        op_q <= bus.Opcode;
      end
      // Leaving HALT needs a fresh rising edge of Run, so arm only after Run=0 is seen
      if (state == S_HALT) begin
        run_armed <= run_armed || !bus.Run;
      end else begin
        run_armed <= 1'b0;
      end
    end
  end

  assign bus.MicroCode = micro_q;
  assign bus.Halted    = halted_q;
  assign bus.Busy      = busy_q;

  // Last cycle of an instruction: single-cycle executes, NOP decode, or completing write
  assign bus.InstrDone = (state == S_EL) || (state == S_EA) || (state == S_ES) ||
                         (state == S_EJ) || (state == S_EZ) ||
                         ((state == S_DEC) && (bus.Opcode == OP_NOP)) ||
                         ((state == S_EW2) && mem_done);

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - scoreboard bench for micro_sequencer
module tb_micro_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  micro_sequencer_if bus ();
  micro_sequencer_if bus2 ();

  micro_sequencer #(.START_ON_RESET(1'b0), .MEM_WAIT(1'b1)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  micro_sequencer #(.START_ON_RESET(1'b1), .MEM_WAIT(1'b0)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  typedef struct packed {
    logic [12:0] mc;
    logic        done;
    logic        busy;
    logic        halt;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] exp2_q[$];
  int          checks = 0;
  int          failures = 0;
  int          idx = 0;
  int          idx2 = 0;

  // Drive one cycle's inputs just after the edge and queue the outputs expected in that cycle
  task automatic cyc(input logic r, input logic run, input logic [2:0] op, input logic mr,
                     input logic [12:0] mc, input logic done, input logic busy, input logic halt);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    bus.Run      = run;
    bus.Opcode   = op;
    bus.MemReady = mr;
    e.mc   = mc;
    e.done = done;
    e.busy = busy;
    e.halt = halt;
    exp_q.push_back(e);
  endtask

  task automatic push2(input logic [12:0] mc);
    exp2_q.push_back(mc);
  endtask

  // Three fetch cycles with memory ready immediately
  task automatic fetch(input logic run, input logic [2:0] op);
    cyc(0, run, op, 1, 13'h020, 0, 1, 0);
    cyc(0, run, op, 1, 13'h040, 0, 1, 0);
    cyc(0, run, op, 1, 13'h800, 0, 1, 0);
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    logic [12:0] m2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.mc   = bus.MicroCode;
      a.done = bus.InstrDone;
      a.busy = bus.Busy;
      a.halt = bus.Halted;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL step%0d mc/done/busy/halt got %h/%b/%b/%b want %h/%b/%b/%b",
                 idx, a.mc, a.done, a.busy, a.halt, e.mc, e.done, e.busy, e.halt);
      end
      idx++;
    end
    if (exp2_q.size() > 0) begin
      m2 = exp2_q.pop_front();
      checks++;
      if (bus2.MicroCode !== m2) begin
        failures++;
        $display("FAIL start_on_reset step%0d mc got %h want %h", idx2, bus2.MicroCode, m2);
      end
      idx2++;
    end
  end

  initial begin
    bus.Run       = 1'b0;
    bus.Opcode    = 3'b000;
    bus.MemReady  = 1'b0;
    bus2.Run      = 1'b0;
    bus2.Opcode   = 3'b000;
    bus2.MemReady = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then LDAC with immediate memory
    cyc(1, 0, 3'b001, 1, 13'h000, 0, 0, 0); push2(13'h000);
    cyc(0, 1, 3'b001, 1, 13'h000, 0, 0, 0); push2(13'h000);
    cyc(0, 1, 3'b001, 1, 13'h020, 0, 1, 0); push2(13'h020);
    cyc(0, 1, 3'b001, 1, 13'h040, 0, 1, 0); push2(13'h040);
    cyc(0, 1, 3'b001, 1, 13'h800, 0, 1, 0); push2(13'h800);
    cyc(0, 1, 3'b001, 1, 13'h1000, 0, 1, 0);
    cyc(0, 1, 3'b001, 1, 13'h040, 0, 1, 0);
    cyc(0, 1, 3'b010, 1, 13'h400, 1, 1, 0);

    // STAC with three wait cycles in EW2, Run dropped mid-instruction
    fetch(0, 3'b010);
    cyc(0, 0, 3'b010, 0, 13'h1000, 0, 1, 0);
    cyc(0, 0, 3'b010, 0, 13'h008, 0, 1, 0);
    cyc(0, 0, 3'b010, 0, 13'h200, 0, 1, 0);
    cyc(0, 0, 3'b010, 0, 13'h200, 0, 1, 0);
    cyc(0, 0, 3'b010, 0, 13'h200, 0, 1, 0);
    cyc(0, 0, 3'b011, 1, 13'h200, 1, 1, 0);

    // ADD then SUB, opcode changed to HALT during ER
    fetch(0, 3'b011);
    cyc(0, 0, 3'b011, 1, 13'h1000, 0, 1, 0);
    cyc(0, 0, 3'b111, 1, 13'h040, 0, 1, 0);
    cyc(0, 0, 3'b100, 1, 13'h004, 1, 1, 0);
    fetch(0, 3'b100);
    cyc(0, 0, 3'b100, 1, 13'h1000, 0, 1, 0);
    cyc(0, 0, 3'b111, 1, 13'h040, 0, 1, 0);
    cyc(0, 0, 3'b101, 1, 13'h002, 1, 1, 0);

    // JUMP, JMPZ, NOP
    fetch(0, 3'b101);
    cyc(0, 0, 3'b101, 1, 13'h1000, 0, 1, 0);
    cyc(0, 0, 3'b110, 1, 13'h100, 1, 1, 0);
    fetch(0, 3'b110);
    cyc(0, 0, 3'b110, 1, 13'h1000, 0, 1, 0);
    cyc(0, 0, 3'b000, 1, 13'h080, 1, 1, 0);
    fetch(0, 3'b000);
    cyc(0, 0, 3'b000, 1, 13'h1000, 1, 1, 0);

    // HALT with Run held high, then Run low/high restarts
    fetch(1, 3'b111);
    cyc(0, 1, 3'b111, 1, 13'h1000, 0, 1, 0);
    cyc(0, 1, 3'b111, 1, 13'h000, 0, 0, 1);
    cyc(0, 1, 3'b111, 1, 13'h000, 0, 0, 1);
    cyc(0, 1, 3'b111, 1, 13'h000, 0, 0, 1);
    cyc(0, 0, 3'b111, 1, 13'h000, 0, 0, 1);
    cyc(0, 1, 3'b111, 1, 13'h000, 0, 0, 1);

    // Restart fetch, stall in F2, reset during the stall
    cyc(0, 0, 3'b001, 0, 13'h020, 0, 1, 0);
    cyc(0, 0, 3'b001, 0, 13'h040, 0, 1, 0);
    cyc(1, 0, 3'b001, 0, 13'h040, 0, 1, 0);
    cyc(0, 0, 3'b001, 1, 13'h000, 0, 0, 0);
    cyc(0, 0, 3'b001, 1, 13'h000, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got %0d want 0", exp_q.size() + exp2_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
